// File: rtl/spi_flash_responder_if.sv
// SPI flash link plus backing-memory read port of the flash responder.
interface spi_flash_responder_if #(
    parameter int unsigned MEM_ADDRESS_SIZE = 9
);
    logic                        flash_csb;
    logic                        flash_sck;
    logic                        flash_io0_write;
    logic                        flash_io1_write;
    logic                        flash_io1_we;
    logic                        mem_csb;
    logic [MEM_ADDRESS_SIZE-1:0] mem_addr;
    logic [31:0]                 mem_dout;

    // Controller / memory side
    modport master (
        output flash_csb, flash_sck, flash_io0_write, mem_dout,
        input  flash_io1_write, flash_io1_we, mem_csb, mem_addr
    );

    // Responder (device) side
    modport slave (
        input  flash_csb, flash_sck, flash_io0_write, mem_dout,
        output flash_io1_write, flash_io1_we, mem_csb, mem_addr
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI flash responder: serves READ (0x03) and RELEASE POWER-DOWN (0xAB) from a
// word-wide memory, oversampling csb/sck/io0 in the clk domain.
// Optional macro FAST_READ_EN adds FAST READ (0x0B) with 8 dummy clocks.
// MEM_ADDRESS_SIZE must be >= 6 so the address shifter also holds a command byte.
module spi_flash_responder #(
    parameter int unsigned MEM_ADDRESS_SIZE = 9,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_flash_responder_if.slave  bus,
    output logic                  active,
    output logic                  cmd_error
);
    localparam int unsigned AW = MEM_ADDRESS_SIZE;
    localparam int unsigned BW = MEM_ADDRESS_SIZE + 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COMMAND = 3'd1,
        S_ADDRESS = 3'd2,
`ifdef FAST_READ_EN
        S_DUMMY   = 3'd5,
`endif
        S_DATA    = 3'd3,
        S_IGNORE  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] csb_sync, sck_sync, io0_sync;
    logic                   csb_s, sck_s, io0_s, sck_d, rise, fall;

    state_t         state, state_n;
    logic [4:0]     bit_cnt, bit_cnt_n;
    logic [BW-2:0]  shift_q, shift_n;
    logic [BW-1:0]  full_in;
    logic [BW-1:0]  byte_addr, byte_addr_n, next_addr;
    logic [31:0]    word_q, word_n;
    logic [7:0]     sr, sr_n;
    logic           io1_q, io1_n, io1_we_q, io1_we_n;
    logic           mem_csb_q, mem_csb_n, load_now;
    logic [AW-1:0]  mem_addr_q, mem_addr_n;
    logic           cmd_err_n;
`ifdef FAST_READ_EN
    logic           fast, fast_n;
`endif

    function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    assign csb_s     = csb_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign io0_s     = io0_sync[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;
    assign full_in   = {shift_q, io0_s};
    assign next_addr = byte_addr + BW'(1);

    assign bus.flash_io1_write = io1_q;
    assign bus.flash_io1_we    = io1_we_q;
    assign bus.mem_csb         = mem_csb_q;
    assign bus.mem_addr        = mem_addr_q;

    // Input synchronizers, sck edge history and registered csb-low indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_sync <= '1;
            sck_sync <= '0;
            io0_sync <= '0;
            sck_d    <= 1'b0;
            active   <= 1'b0;
        end else begin
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], bus.flash_csb};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.flash_sck};
            io0_sync <= {io0_sync[SYNC_STAGES-2:0], bus.flash_io0_write};
            sck_d    <= sck_s;
            active   <= ~csb_s;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            byte_addr  <= '0;
            word_q     <= '0;
            sr         <= '0;
            io1_q      <= 1'b0;
            io1_we_q   <= 1'b0;
            mem_csb_q  <= 1'b1;
            mem_addr_q <= '0;
            load_now   <= 1'b0;
            cmd_error  <= 1'b0;
`ifdef FAST_READ_EN
            fast       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            byte_addr  <= byte_addr_n;
            word_q     <= word_n;
            sr         <= sr_n;
            io1_q      <= io1_n;
            io1_we_q   <= io1_we_n;
            mem_csb_q  <= mem_csb_n;
            mem_addr_q <= mem_addr_n;
            load_now   <= ~mem_csb_q;
            cmd_error  <= cmd_err_n;
`ifdef FAST_READ_EN
            fast       <= fast_n;
`endif
        end
    end

    // Next-state and next-value logic; csb high overrides every sck edge
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_q;
        byte_addr_n = byte_addr;
        word_n      = word_q;
        sr_n        = sr;
        io1_n       = io1_q;
        io1_we_n    = io1_we_q;
        mem_csb_n   = 1'b1;
        mem_addr_n  = mem_addr_q;
        cmd_err_n   = 1'b0;
`ifdef FAST_READ_EN
        fast_n      = fast;
`endif
        // Memory word arrives one clk after the strobe; latch it and its lane
        if (load_now) begin
            word_n = bus.mem_dout;
            sr_n   = lane_of(bus.mem_dout, byte_addr[1:0]);
        end

        if (csb_s) begin
            state_n   = S_IDLE;
            io1_we_n  = 1'b0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n   = S_COMMAND;
                    bit_cnt_n = '0;
                    shift_n   = '0;
`ifdef FAST_READ_EN
                    fast_n    = 1'b0;
`endif
                end
                S_COMMAND: if (rise) begin
                    shift_n   = full_in[BW-2:0];
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt_n = '0;
                        case (full_in[7:0])
                            8'h03: state_n = S_ADDRESS;
`ifdef FAST_READ_EN
                            8'h0B: begin
                                state_n = S_ADDRESS;
                                fast_n  = 1'b1;
                            end
`endif
                            8'hAB: state_n = S_IGNORE;
                            default: begin
                                state_n   = S_IGNORE;
                                cmd_err_n = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDRESS: if (rise) begin
                    shift_n   = full_in[BW-2:0];
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23) begin
                        bit_cnt_n   = '0;
                        byte_addr_n = full_in;
                        mem_csb_n   = 1'b0;
                        mem_addr_n  = full_in[BW-1:2];
`ifdef FAST_READ_EN
                        state_n     = fast ? S_DUMMY : S_DATA;
                        io1_we_n    = ~fast;
`else
                        state_n     = S_DATA;
                        io1_we_n    = 1'b1;
`endif
                    end
                end
`ifdef FAST_READ_EN
                S_DUMMY: if (rise) begin
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        bit_cnt_n = '0;
                        state_n   = S_DATA;
                        io1_we_n  = 1'b1;
                    end
                end
`endif
                S_DATA: begin
                    if (fall) begin
                        io1_n = sr[7];
                        sr_n  = {sr[6:0], 1'b0};
                    end
                    // Byte sampled by the controller: advance, fetch only on lane wrap
                    if (rise) begin
                        bit_cnt_n = bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt_n   = '0;
                            byte_addr_n = next_addr;
                            if (next_addr[1:0] == 2'd0) begin
                                mem_csb_n  = 1'b0;
                                mem_addr_n = next_addr[BW-1:2];
                            end else begin
                                sr_n = lane_of(word_q, next_addr[1:0]);
                            end
                        end
                    end
                end
                S_IGNORE: state_n = S_IGNORE;
                default:  state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized scoreboard bench for spi_flash_responder: a bus-functional SPI
// controller, a synchronous memory model and independent output monitors.
module tb_spi_flash_responder;
    localparam int unsigned AW    = 9;
    localparam int unsigned SS    = 2;
    localparam int unsigned H     = 5;
    localparam int unsigned WORDS = 2 ** AW;
    localparam int unsigned BYTES = 4 * WORDS;

    logic clk = 1'b0;
    logic rst_n;
    logic active, cmd_error;

    always #5 clk = ~clk;

    spi_flash_responder_if #(.MEM_ADDRESS_SIZE(AW)) bus ();

    spi_flash_responder #(.MEM_ADDRESS_SIZE(AW), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .active    (active),
        .cmd_error (cmd_error)
    );

    logic [31:0] mem [WORDS];
    logic [7:0]  exp_bytes [$];
    int unsigned exp_rd [$];
    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    int          last_rd = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          mon_bits = 0;
    logic [7:0]  mon_sh = 8'h00;
    bit          in_data = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference byte at a flash address: memory is little-endian bytes per word
    function automatic logic [7:0] ref_byte(input int unsigned a);
        int unsigned b;
        logic [31:0] w;
        b = a % BYTES;
        w = mem[b / 4] >> (8 * (b % 4));
        return w[7:0];
    endfunction

    // Synchronous memory: data one clk after the strobe
    always @(posedge clk)
        if (bus.mem_csb == 1'b0) bus.mem_dout <= mem[bus.mem_addr];

    // Memory-read monitor
    always @(negedge clk) begin
        if (rst_n && bus.mem_csb === 1'b0) begin
            rd_count++;
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_read_unexpected actual=%0h required=none", bus.mem_addr);
            end else begin
                chk("mem_addr", 32'(bus.mem_addr), exp_rd.pop_front());
            end
        end
        if (rst_n && cmd_error === 1'b1) err_seen++;
    end

    // Data monitor: controller samples io1 on each sck rise
    always @(posedge bus.flash_sck) begin
        if (in_data) begin
            last_rd  = rd_count;
            mon_sh   = {mon_sh[6:0], bus.flash_io1_write};
            mon_bits = mon_bits + 1;
            if (mon_bits == 8) begin
                mon_bits = 0;
                chk("io1_we_in_data", 32'(bus.flash_io1_we), 32'd1);
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_unexpected actual=%0h required=none", mon_sh);
                end else begin
                    chk("data_byte", 32'(mon_sh), 32'(exp_bytes.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.flash_io0_write = b;
        tick(H);
        bus.flash_sck = 1'b1;
        tick(H);
        bus.flash_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic cs_low();
        bus.flash_csb = 1'b0;
        tick(4);
        chk("active_low_cs", 32'(active), 32'd1);
    endtask

    task automatic cs_high_check();
        tick(2);
        bus.flash_csb = 1'b1;
        tick(SS + 1);
        chk("io1_we_release", 32'(bus.flash_io1_we), 32'd0);
        chk("active_release", 32'(active), 32'd0);
        tick(3);
    endtask

    // Full read transaction with scoreboard expectations
    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr,
                        input int ndummy, input int nbytes, output int reads_during);
        int unsigned ba;
        int          rd_start;
        ba = addr % BYTES;
        for (int k = 0; k < nbytes; k++) exp_bytes.push_back(ref_byte(ba + k));
        exp_rd.push_back(ba / 4);
        for (int k = 1; k <= nbytes; k++)
            if (((ba + k) % BYTES) % 4 == 0) exp_rd.push_back(((ba + k) % BYTES) / 4);
        rd_start = rd_count;
        cs_low();
        send_byte(cmd);
        for (int i = 23; i >= 0; i--) send_bit(addr[i]);
        for (int i = 0; i < ndummy; i++) send_bit(1'b0);
        mon_bits = 0;
        in_data  = 1'b1;
        for (int i = 0; i < nbytes * 8; i++) send_bit(1'b0);
        in_data  = 1'b0;
        reads_during = last_rd - rd_start;
        cs_high_check();
    endtask

    // Unsupported or ignored command: io1 must stay released
    task automatic bad_cmd(input logic [7:0] cmd, input bit is_err);
        bit we_seen;
        we_seen = 1'b0;
        cs_low();
        send_byte(cmd);
        if (is_err) exp_err++;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (bus.flash_io1_we !== 1'b0) we_seen = 1'b1;
            if (i % 8 == 0) bus.flash_sck = ~bus.flash_sck;
        end
        bus.flash_sck = 1'b0;
        chk("io1_we_ignore", 32'(we_seen), 32'd0);
        chk("cmd_error_count", 32'(err_seen), 32'(exp_err));
        cs_high_check();
    endtask

    task automatic abort_addr(input int nbits);
        cs_low();
        send_byte(8'h03);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
        bus.flash_csb = 1'b1;
        tick(SS + 1);
        chk("io1_we_abort", 32'(bus.flash_io1_we), 32'd0);
        chk("active_abort", 32'(active), 32'd0);
        tick(3);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int kind;
        logic [7:0] cmds [5];
        cmds[0] = 8'h9F; cmds[1] = 8'h05; cmds[2] = 8'h06; cmds[3] = 8'hFF; cmds[4] = 8'h00;
        for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;

        rst_n = 1'b0;
        bus.flash_csb = 1'b1;
        bus.flash_sck = 1'b0;
        bus.flash_io0_write = 1'b0;
        tick(4);
        chk("rst_io1_write", 32'(bus.flash_io1_write), 32'd0);
        chk("rst_io1_we", 32'(bus.flash_io1_we), 32'd0);
        chk("rst_mem_csb", 32'(bus.mem_csb), 32'd1);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_cmd_error", 32'(cmd_error), 32'd0);
        rst_n = 1'b1;
        tick(4);

        xfer(8'h03, 24'h000000, 0, 8, rd);
        chk("reads_during_8_bytes", 32'(rd), 32'd2);
        xfer(8'h03, 24'h000002, 0, 3, rd);
        xfer(8'h03, 24'(BYTES - 1), 0, 2, rd);
        xfer(8'h03, 24'(BYTES), 0, 1, rd);
        bad_cmd(8'h9F, 1'b1);
        xfer(8'h03, 24'h000000, 0, 1, rd);
        bad_cmd(8'hAB, 1'b0);
        abort_addr(12);
        xfer(8'h03, 24'h000004, 0, 1, rd);
`ifdef FAST_READ_EN
        xfer(8'h0B, 24'h000001, 8, 2, rd);
`else
        bad_cmd(8'h0B, 1'b1);
`endif

        for (int it = 0; it < 16; it++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0)
                xfer(8'h03, 24'($urandom), 0, int'($urandom_range(1, 6)), rd);
            else if (kind == 1)
                abort_addr(int'($urandom_range(1, 23)));
            else
                bad_cmd(cmds[$urandom_range(0, 4)], 1'b1);
        end

        tick(10);
        chk("exp_bytes_drained", 32'(exp_bytes.size()), 32'd0);
        chk("exp_reads_drained", 32'(exp_rd.size()), 32'd0);
        chk("cmd_error_total", 32'(err_seen), 32'(exp_err));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
